iram_apb_stager: RTL and testbench

IRAM_APB_STAGER -- requirements
Module: iram_apb_stager

---
 rtl/iram_apb_stager.sv | 200 ++++++++++++++++++++
 tb/tb_iram_apb_stager.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iram_apb_stager.sv
// Instruction RAM with a core fetch port, an init lane-write port, and an APB
// staging window for committing and reading back whole words after init.
module iram_apb_stager #(
    parameter int DWIDTH     = 16,
    parameter int IWIDTH     = 30,
    parameter int ICWIDTH    = 7,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 INITDATVAL,
    input  logic                 INITDONE,
    input  logic [ICWIDTH+2:0]   INITADDR,
    input  logic [8:0]           INITDATA,
    input  logic                 FETCH_EN,
    input  logic [ICWIDTH-1:0]   ADDRESS,
    output logic [IWIDTH-1:0]    INSTRUCTION,
    output logic                 FETCH_VALID,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [4:0]           PADDR,
    input  logic [DWIDTH-1:0]    PWDATA,
    output logic [DWIDTH-1:0]    PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR
);
    localparam int NCOLS  = (IWIDTH + 8) / 9;
    localparam int NBEATS = (IWIDTH + DWIDTH - 1) / DWIDTH;
    localparam int MW     = NCOLS * 9;
    localparam int SW     = NBEATS * DWIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int DEPTH  = 1 << ICWIDTH;

    localparam logic [2:0] R_CTRL = 3'd0, R_ADDR = 3'd1, R_BEAT = 3'd2;
    localparam logic [2:0] R_DATA = 3'd3, R_CMD = 3'd4, R_STATUS = 3'd5;

    typedef enum logic [1:0] {IDLE, RWAIT, RCAP} state_t;
    state_t state_reg, state_next;

    logic [MW-1:0]      mem [DEPTH];
    logic [DWIDTH-1:0]  stage_reg [NBEATS];
    logic [SW-1:0]      stage_flat, rdbuf_pad;
    logic [IWIDTH-1:0]  rdbuf_reg, instr_reg;
    logic [DWIDTH-1:0]  prdata_reg, rd_mux;
    logic [ICWIDTH-1:0] addr_reg, init_word, wr_addr;
    logic [BW-1:0]      beat_reg, beat_inc;
    logic [7:0]         wait_reg;
    logic [2:0]         reg_sel, init_lane;
    logic [NCOLS-1:0]   wr_be;
    logic [MW-1:0]      wr_data;
    logic lock_reg, autoinc_reg, err_reg, pready_reg, pslverr_reg, fetch_valid_reg;
    logic setup, wr_acc, rd_acc, cmd_commit, cmd_rb, cmd_err;
    logic commit_go, init_go, grant, fetch_go, unused_bits;

    assign reg_sel    = PADDR[4:2];
    assign setup      = PSEL && !PENABLE && (state_reg == IDLE);
    assign wr_acc     = PSEL && PENABLE && PWRITE && (state_reg == IDLE);
    assign rd_acc     = PSEL && PENABLE && !PWRITE && (state_reg == IDLE);
    assign cmd_commit = (PWDATA == DWIDTH'(1));
    assign cmd_rb     = (PWDATA == DWIDTH'(2));
    assign cmd_err    = (cmd_commit && (lock_reg || !INITDONE)) || (cmd_rb && !INITDONE)
                      || (!cmd_commit && !cmd_rb);
    // Access-phase decisions reuse the error verdict registered during setup.
    assign commit_go  = wr_acc && (reg_sel == R_CMD) && cmd_commit && !pslverr_reg && INITDONE;
    assign init_lane  = INITADDR[ICWIDTH+2:ICWIDTH];
    assign init_word  = INITADDR[ICWIDTH-1:0];
    assign init_go    = INITDATVAL && !INITDONE && (32'(init_lane) < NCOLS);
    assign fetch_go   = FETCH_EN && !grant;
    assign beat_inc   = (beat_reg == BW'(NBEATS - 1)) ? '0 : beat_reg + 1'b1;
    assign rdbuf_pad  = SW'(rdbuf_reg);
    assign unused_bits = ^{PADDR[1:0], stage_flat};

    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_stage_flat
            assign stage_flat[gi*DWIDTH +: DWIDTH] = stage_reg[gi];
        end
    endgenerate

    always_comb begin
        wr_addr = init_word;
        wr_be   = '0;
        wr_data = {NCOLS{INITDATA}};
        if (commit_go) begin
            wr_addr = addr_reg;
            wr_be   = '1;
            wr_data = MW'(stage_flat[IWIDTH-1:0]);
        end else if (init_go) begin
            for (int i = 0; i < NCOLS; i++) wr_be[i] = (init_lane == 3'(i));
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCOLS; i++)
            if (wr_be[i]) mem[wr_addr][i*9 +: 9] <= wr_data[i*9 +: 9];
    end

    assert property (@(posedge CLK) disable iff (!RSTN)
        !(commit_go && init_go && (addr_reg == init_word)));

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE:  if (wr_acc && (reg_sel == R_CMD) && !pready_reg) state_next = RWAIT;
            RWAIT: if (!FETCH_EN || (wait_reg == 8'(RD_TIMEOUT - 1))) begin
                       grant      = 1'b1;
                       state_next = RCAP;
                   end
            RCAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Shared read port: a granted readback steals the cycle from the fetch.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            instr_reg       <= '0;
            fetch_valid_reg <= 1'b0;
            rdbuf_reg       <= '0;
        end else begin
            fetch_valid_reg <= fetch_go;
            if (fetch_go) instr_reg <= mem[ADDRESS][IWIDTH-1:0];
            if (grant)    rdbuf_reg <= mem[addr_reg][IWIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            R_CTRL:   rd_mux = DWIDTH'({autoinc_reg, lock_reg});
            R_ADDR:   rd_mux = DWIDTH'(addr_reg);
            R_BEAT:   rd_mux = DWIDTH'(beat_reg);
            R_DATA:   rd_mux = rdbuf_pad[beat_reg*DWIDTH +: DWIDTH];
            R_STATUS: rd_mux = DWIDTH'({err_reg, INITDONE, state_reg != IDLE});
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
            pready_reg  <= 1'b1;
            lock_reg    <= 1'b0;
            autoinc_reg <= 1'b0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            beat_reg    <= '0;
            wait_reg    <= '0;
            for (int i = 0; i < NBEATS; i++) stage_reg[i] <= '0;
        end else begin
            // Response is decided in the setup phase so the access phase sees registered values.
            if (setup) begin
                prdata_reg  <= PWRITE ? '0 : rd_mux;
                pslverr_reg <= PWRITE && (reg_sel == R_CMD) && cmd_err;
                pready_reg  <= !(PWRITE && (reg_sel == R_CMD) && cmd_rb && !cmd_err);
            end
            if (state_reg == IDLE)                 wait_reg <= '0;
            else if (state_reg == RWAIT && !grant) wait_reg <= wait_reg + 1'b1;
            if (grant)               pready_reg <= 1'b1;
            if (state_reg == RCAP)   beat_reg   <= '0;
            if (wr_acc) begin
                case (reg_sel)
                    R_CTRL: begin
                        lock_reg    <= lock_reg | PWDATA[0];
                        autoinc_reg <= PWDATA[1];
                    end
                    R_ADDR: addr_reg <= ICWIDTH'(PWDATA);
                    R_BEAT: beat_reg <= (PWDATA < DWIDTH'(NBEATS)) ? BW'(PWDATA) : '0;
                    R_DATA: begin
                        stage_reg[beat_reg] <= PWDATA;
                        beat_reg            <= beat_inc;
                    end
                    R_CMD: begin
                        if (pslverr_reg) err_reg <= 1'b1;
                        else if (commit_go) begin
                            beat_reg <= '0;
                            if (autoinc_reg) addr_reg <= addr_reg + 1'b1;
                        end
                    end
                    R_STATUS: if (PWDATA[2]) err_reg <= 1'b0;
                    default: ;
                endcase
            end
            if (rd_acc && (reg_sel == R_DATA)) beat_reg <= beat_inc;
        end
    end

    assign INSTRUCTION = instr_reg;
    assign FETCH_VALID = fetch_valid_reg;
    assign PRDATA      = prdata_reg;
    assign PREADY      = pready_reg;
    assign PSLVERR     = pslverr_reg;
endmodule

// File: tb/tb_iram_apb_stager.sv
// Directed bench: init/fetch, APB staging commit, readback stealing, lock,
// autoinc wrap and reset abort, each checked against hand-computed values.
module tb_iram_apb_stager;
    localparam int DW = 16, IW = 30, ICW = 7, RDT = 15;
    localparam logic [4:0] A_CTRL = 5'h00, A_ADDR = 5'h04, A_BEAT = 5'h08;
    localparam logic [4:0] A_DATA = 5'h0C, A_CMD = 5'h10, A_STATUS = 5'h14;

    logic CLK = 1'b0, RSTN = 1'b0, INITDATVAL = 1'b0, INITDONE = 1'b0;
    logic [ICW+2:0] INITADDR = '0;
    logic [8:0] INITDATA = '0;
    logic FETCH_EN = 1'b0;
    logic [ICW-1:0] ADDRESS = '0;
    logic [IW-1:0] INSTRUCTION;
    logic FETCH_VALID;
    logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0] PADDR = '0;
    logic [DW-1:0] PWDATA = '0, PRDATA;
    logic PREADY, PSLVERR;

    int n_checks = 0, n_errors = 0, fv_zero = 0;
    logic mon_en = 1'b0;

    always #5 CLK = ~CLK;

    iram_apb_stager #(.DWIDTH(DW), .IWIDTH(IW), .ICWIDTH(ICW), .RD_TIMEOUT(RDT)) dut (
        .CLK(CLK), .RSTN(RSTN), .INITDATVAL(INITDATVAL), .INITDONE(INITDONE),
        .INITADDR(INITADDR), .INITDATA(INITDATA), .FETCH_EN(FETCH_EN), .ADDRESS(ADDRESS),
        .INSTRUCTION(INSTRUCTION), .FETCH_VALID(FETCH_VALID), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always @(negedge CLK) if (mon_en && !FETCH_VALID) fv_zero++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rdata, output logic slverr, output int waits);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(negedge CLK);
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 64) begin
            @(negedge CLK);
            waits++;
        end
        check("pready_done", PREADY, 1);
        rdata = PRDATA;
        slverr = PSLVERR;
        $display("apb %s addr=0x%02h wdata=0x%04h rdata=0x%04h slverr=%0b waits=%0d",
                 wr ? "wr" : "rd", a, d, rdata, slverr, waits);
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_wr(input string tag, input logic [4:0] a, input logic [DW-1:0] d,
                          input logic exp_err);
        logic [DW-1:0] rv;
        logic e;
        int w;
        apb_xfer(1'b1, a, d, rv, e, w);
        check(tag, e, exp_err);
    endtask

    task automatic apb_rd(input string tag, input logic [4:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] rv;
        logic e;
        int w;
        apb_xfer(1'b0, a, '0, rv, e, w);
        check(tag, rv, exp);
    endtask

    task automatic init_wr(input logic [2:0] lane, input logic [ICW-1:0] word, input logic [8:0] d);
        @(negedge CLK);
        INITDATVAL = 1'b1; INITADDR = {lane, word}; INITDATA = d;
        @(negedge CLK);
        INITDATVAL = 1'b0;
        $display("init lane=%0d word=%0d data=0x%03h", lane, word, d);
    endtask

    task automatic fetch(input string tag, input logic [ICW-1:0] a, input logic [IW-1:0] exp);
        @(negedge CLK);
        FETCH_EN = 1'b1; ADDRESS = a;
        @(negedge CLK);
        FETCH_EN = 1'b0;
        $display("fetch addr=%0d valid=%0b instr=0x%08h", a, FETCH_VALID, INSTRUCTION);
        check({tag, "_valid"}, FETCH_VALID, 1);
        check(tag, INSTRUCTION, exp);
    endtask

    initial begin
        logic [DW-1:0] rv;
        logic e;
        int w, base;

        repeat (3) @(negedge CLK);
        check("rst_pready", PREADY, 1);
        check("rst_fvalid", FETCH_VALID, 0);
        check("rst_instr", INSTRUCTION, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_slverr", PSLVERR, 0);
        RSTN = 1'b1;

        init_wr(3'd0, 7'd5, 9'h1AB);
        init_wr(3'd1, 7'd5, 9'h0CD);
        init_wr(3'd2, 7'd5, 9'h1EF);
        init_wr(3'd3, 7'd5, 9'h012);
        init_wr(3'd4, 7'd5, 9'h1FF);   // lane beyond NCOLS, must be dropped

        apb_wr("rb_noinit_err", A_CMD, 16'd2, 1'b1);
        apb_rd("status_err_noinit", A_STATUS, 16'h0004);
        apb_wr("clr_err", A_STATUS, 16'h0004, 1'b0);
        apb_rd("status_cleared", A_STATUS, 16'h0000);

        INITDONE = 1'b1;
        fetch("fetch5", 7'd5, 30'h17BD9BAB);
        @(negedge CLK);
        check("fvalid_idle", FETCH_VALID, 0);
        check("instr_hold", INSTRUCTION, 30'h17BD9BAB);

        apb_wr("addr7", A_ADDR, 16'd7, 1'b0);
        apb_wr("data_lo", A_DATA, 16'h1234, 1'b0);
        apb_rd("beat_after_one", A_BEAT, 16'd1);
        apb_wr("data_hi", A_DATA, 16'h2ABC, 1'b0);
        apb_wr("commit_ok", A_CMD, 16'd1, 1'b0);
        apb_rd("beat_after_commit", A_BEAT, 16'd0);
        apb_rd("addr_no_inc", A_ADDR, 16'd7);
        fetch("fetch7", 7'd7, 30'h2ABC1234);

        apb_wr("addr5", A_ADDR, 16'd5, 1'b0);
        @(negedge CLK);
        FETCH_EN = 1'b1; ADDRESS = 7'd7;
        @(negedge CLK);
        #1 mon_en = 1'b1;
        base = fv_zero;
        apb_xfer(1'b1, A_CMD, 16'd2, rv, e, w);
        check("rb_steal_slverr", e, 0);
        check("rb_steal_waits", w, RDT + 1);
        repeat (2) @(negedge CLK);
        #1 mon_en = 1'b0;
        FETCH_EN = 1'b0;
        check("rb_steal_fv_gaps", fv_zero - base, 1);
        check("rb_steal_instr", INSTRUCTION, 30'h2ABC1234);
        apb_rd("rb5_beat0", A_DATA, 16'h9BAB);
        apb_rd("rb5_beat1", A_DATA, 16'h17BD);
        apb_rd("rb5_beat_wrap", A_BEAT, 16'd0);

        apb_wr("addr7b", A_ADDR, 16'd7, 1'b0);
        apb_xfer(1'b1, A_CMD, 16'd2, rv, e, w);
        check("rb_idle_waits", w, 2);
        apb_rd("rb7_beat0", A_DATA, 16'h1234);
        apb_rd("rb7_beat1", A_DATA, 16'h2ABC);

        apb_wr("ctrl_autoinc", A_CTRL, 16'h0002, 1'b0);
        apb_wr("addr127", A_ADDR, 16'd127, 1'b0);
        apb_wr("data_beef", A_DATA, 16'hBEEF, 1'b0);
        apb_wr("data_0001", A_DATA, 16'h0001, 1'b0);
        apb_wr("commit_wrap", A_CMD, 16'd1, 1'b0);
        apb_rd("addr_wrapped", A_ADDR, 16'd0);
        fetch("fetch127", 7'd127, 30'h0001BEEF);

        apb_wr("addr7c", A_ADDR, 16'd7, 1'b0);
        apb_wr("data_ffff", A_DATA, 16'hFFFF, 1'b0);
        apb_wr("data_3fff", A_DATA, 16'h3FFF, 1'b0);
        apb_wr("ctrl_lock", A_CTRL, 16'h0003, 1'b0);
        apb_wr("commit_locked_err", A_CMD, 16'd1, 1'b1);
        apb_rd("status_err_lock", A_STATUS, 16'h0006);
        apb_rd("addr_unchanged", A_ADDR, 16'd7);
        fetch("fetch7_locked", 7'd7, 30'h2ABC1234);
        apb_wr("cmd3_err", A_CMD, 16'd3, 1'b1);
        apb_wr("ctrl_clear_try", A_CTRL, 16'h0000, 1'b0);
        apb_rd("ctrl_lock_sticky", A_CTRL, 16'h0001);
        apb_wr("clr_err2", A_STATUS, 16'h0004, 1'b0);
        apb_rd("status_clear2", A_STATUS, 16'h0002);

        @(negedge CLK);
        FETCH_EN = 1'b1; ADDRESS = 7'd7;
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_CMD; PWDATA = 16'd2;
        @(negedge CLK);
        PENABLE = 1'b1;
        repeat (5) @(negedge CLK);
        check("rwait_pready_low", PREADY, 0);
        #1 RSTN = 1'b0;
        #1;
        check("abort_pready", PREADY, 1);
        check("abort_fvalid", FETCH_VALID, 0);
        $display("reset asserted during readback wait");
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; FETCH_EN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        apb_rd("status_after_abort", A_STATUS, 16'h0002);
        apb_rd("ctrl_after_abort", A_CTRL, 16'h0000);
        apb_rd("addr_after_abort", A_ADDR, 16'h0000);
        fetch("fetch7_kept", 7'd7, 30'h2ABC1234);
        fetch("fetch5_kept", 7'd5, 30'h17BD9BAB);
        fetch("fetch127_kept", 7'd127, 30'h0001BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
